dl_bus_sequencer: RTL and testbench

Sequencer and arbiter for the core's 8-bit internal data bus DL and the external data bus path. Four requesters share the bus: ALU result to DL, DV operand to DL, external read (D to DL), and external write (DL to D). The block grants one transfer at a time and runs a fixed precharge/drive/done sequence per transfer. It generates the DL_Control2 (Res to DL) and DataOut (DV to DL) enables plus the external drive and sample strobes used by the per-bit data multiplexer.

---
 rtl/dl_seq_pkg.sv | 29 ++
 rtl/rr_arbiter4.sv | 28 ++
 rtl/dl_bus_sequencer.sv | 126 ++++++++++++
 tb/tb_dl_bus_sequencer.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dl_seq_pkg.sv
// Shared types and constants for the DL bus sequencer.
// State encoding, requester slots and hold counter width.
package dl_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRE   = 2'd1,
        DRIVE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int REQ_RES = 0;
    localparam int REQ_DV  = 1;
    localparam int REQ_RD  = 2;
    localparam int REQ_WR  = 3;

    localparam int HOLD_W = 3;

    // Slot index of a one-hot requester vector.
    function automatic logic [1:0] idx_of(input logic [3:0] oh);
        logic [1:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            if (oh[i]) r = 2'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// Four-way round-robin pick.
// Search starts at the pointer slot and wraps; result is one-hot.
module rr_arbiter4
    import dl_seq_pkg::*;
(
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [3:0] gnt
);

    logic [1:0] idx;
    logic       found;

    // First requesting slot at or after the pointer wins.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = ptr;
        for (int i = 0; i < 4; i++) begin
            idx = ptr + 2'(i);
            if (req[idx] && !found) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dl_bus_sequencer.sv
// DL bus arbiter and precharge/drive/done sequencer.
// All outputs registered; Test1 kills external transfers.
module dl_bus_sequencer
    import dl_seq_pkg::*;
#(
    parameter int HOLD_CYCLES = 1
) (
    input  logic CLK,
    input  logic RESET,
    input  logic Test1,
    input  logic req_res,
    input  logic req_dv,
    input  logic req_rd,
    input  logic req_wr,
    input  logic wr_src,
    output logic gnt_res,
    output logic gnt_dv,
    output logic gnt_rd,
    output logic gnt_wr,
    output logic DL_Control2,
    output logic DataOut,
    output logic ext_drive,
    output logic dl_sample,
    output logic done,
    output logic abort,
    output logic busy
);

    state_t              state;
    logic [1:0]          ptr;
    logic [3:0]          gnt;
    logic [HOLD_W-1:0]   cnt;
    logic                wsrc_q;
    logic [3:0]          elig;
    logic [3:0]          cand;
    logic [3:0]          win;
    logic                ext_gnt;

    assign elig    = {req_wr & ~Test1, req_rd & ~Test1, req_dv, req_res};
    assign cand    = elig & ~gnt;
    assign ext_gnt = gnt[REQ_RD] | gnt[REQ_WR];

    assign gnt_res = gnt[REQ_RES];
    assign gnt_dv  = gnt[REQ_DV];
    assign gnt_rd  = gnt[REQ_RD];
    assign gnt_wr  = gnt[REQ_WR];

    rr_arbiter4 u_arb (
        .req (cand),
        .ptr (ptr),
        .gnt (win)
    );

    // Transfer sequencing, grant/pointer update and registered strobes.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state       <= IDLE;
            ptr         <= '0;
            gnt         <= '0;
            cnt         <= '0;
            wsrc_q      <= 1'b0;
            DL_Control2 <= 1'b0;
            DataOut     <= 1'b0;
            ext_drive   <= 1'b0;
            dl_sample   <= 1'b0;
            done        <= 1'b0;
            abort       <= 1'b0;
            busy        <= 1'b0;
        end else begin
            done      <= 1'b0;
            dl_sample <= 1'b0;
            abort     <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    if (|win) begin
                        gnt   <= win;
                        state <= PRE;
                        busy  <= 1'b1;
                        ptr   <= idx_of(win) + 2'd1;
                        if (win[REQ_WR]) wsrc_q <= wr_src;
                    end else begin
                        gnt   <= '0;
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                PRE: begin
                    if (ext_gnt && Test1) begin
                        gnt   <= '0;
                        state <= IDLE;
                        busy  <= 1'b0;
                        abort <= 1'b1;
                    end else begin
                        state       <= DRIVE;
                        cnt         <= HOLD_W'(HOLD_CYCLES - 1);
                        DL_Control2 <= gnt[REQ_RES] | (gnt[REQ_WR] & ~wsrc_q);
                        DataOut     <= gnt[REQ_DV] | (gnt[REQ_WR] & wsrc_q);
                        ext_drive   <= gnt[REQ_WR];
                    end
                end
                DRIVE: begin
                    if (ext_gnt && Test1) begin
                        gnt         <= '0;
                        state       <= IDLE;
                        busy        <= 1'b0;
                        abort       <= 1'b1;
                        DL_Control2 <= 1'b0;
                        DataOut     <= 1'b0;
                        ext_drive   <= 1'b0;
                    end else if (cnt == '0) begin
                        state       <= DONE;
                        done        <= 1'b1;
                        dl_sample   <= ~gnt[REQ_WR];
                        DL_Control2 <= 1'b0;
                        DataOut     <= 1'b0;
                        ext_drive   <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dl_bus_sequencer.sv
// Directed bench for dl_bus_sequencer with a transaction-level model.
// Two instances (hold 1 and hold 3) share one stimulus stream.
module tb_dl_bus_sequencer;

    logic CLK;
    logic RESET;
    logic Test1;
    logic req_res, req_dv, req_rd, req_wr;
    logic wr_src;

    logic a_gres, a_gdv, a_grd, a_gwr, a_dlc, a_dout, a_ext;
    logic a_smp, a_done, a_abort, a_busy;
    logic b_gres, b_gdv, b_grd, b_gwr, b_dlc, b_dout, b_ext;
    logic b_smp, b_done, b_abort, b_busy;

    logic [10:0] ov [2];

    int checks;
    int errors;
    bit chk_en;

    // model state per instance: owner slot (-1 none), phase time,
    // round-robin pointer, latched write source, abort pulse
    int m_own [2];
    int m_t   [2];
    int m_ptr [2];
    bit m_ws  [2];
    bit m_ab  [2];

    dl_bus_sequencer #(.HOLD_CYCLES(1)) dut_a (
        .CLK(CLK), .RESET(RESET), .Test1(Test1),
        .req_res(req_res), .req_dv(req_dv),
        .req_rd(req_rd), .req_wr(req_wr), .wr_src(wr_src),
        .gnt_res(a_gres), .gnt_dv(a_gdv),
        .gnt_rd(a_grd), .gnt_wr(a_gwr),
        .DL_Control2(a_dlc), .DataOut(a_dout),
        .ext_drive(a_ext), .dl_sample(a_smp),
        .done(a_done), .abort(a_abort), .busy(a_busy)
    );

    dl_bus_sequencer #(.HOLD_CYCLES(3)) dut_b (
        .CLK(CLK), .RESET(RESET), .Test1(Test1),
        .req_res(req_res), .req_dv(req_dv),
        .req_rd(req_rd), .req_wr(req_wr), .wr_src(wr_src),
        .gnt_res(b_gres), .gnt_dv(b_gdv),
        .gnt_rd(b_grd), .gnt_wr(b_gwr),
        .DL_Control2(b_dlc), .DataOut(b_dout),
        .ext_drive(b_ext), .dl_sample(b_smp),
        .done(b_done), .abort(b_abort), .busy(b_busy)
    );

    assign ov[0] = {a_gres, a_gdv, a_grd, a_gwr, a_dlc, a_dout,
                    a_ext, a_smp, a_done, a_abort, a_busy};
    assign ov[1] = {b_gres, b_gdv, b_grd, b_gwr, b_dlc, b_dout,
                    b_ext, b_smp, b_done, b_abort, b_busy};

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic int hold_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    // Phases: t=0 precharge, 1..H drive, H+1 done.
    function automatic logic [10:0] exp_vec(input int i);
        logic [10:0] v;
        int  o, t, h;
        bit  drv, dn;
        o   = m_own[i];
        t   = m_t[i];
        h   = hold_of(i);
        drv = (o >= 0) && (t >= 1) && (t <= h);
        dn  = (o >= 0) && (t == h + 1);
        v[10] = (o == 0);
        v[9]  = (o == 1);
        v[8]  = (o == 2);
        v[7]  = (o == 3);
        v[6]  = drv && ((o == 0) || ((o == 3) && !m_ws[i]));
        v[5]  = drv && ((o == 1) || ((o == 3) && m_ws[i]));
        v[4]  = drv && (o == 3);
        v[3]  = dn && (o != 3);
        v[2]  = dn;
        v[1]  = m_ab[i];
        v[0]  = (o >= 0);
        return v;
    endfunction

    // Model advances on every clock edge from the sampled inputs.
    always @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < 2; i++) begin
                m_own[i] = -1;
                m_t[i]   = 0;
                m_ptr[i] = 0;
                m_ws[i]  = 1'b0;
                m_ab[i]  = 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                int h, prev, c;
                bit [3:0] rq;
                rq = {req_wr, req_rd, req_dv, req_res};
                h  = hold_of(i);
                m_ab[i] = 1'b0;
                if (m_own[i] >= 2 && m_t[i] <= h && Test1) begin
                    m_own[i] = -1;
                    m_ab[i]  = 1'b1;
                end else if (m_own[i] >= 0 && m_t[i] <= h) begin
                    m_t[i] = m_t[i] + 1;
                end else begin
                    prev     = m_own[i];
                    m_own[i] = -1;
                    for (int k = 0; k < 4; k++) begin
                        c = (m_ptr[i] + k) % 4;
                        if (m_own[i] < 0 && rq[c] && c != prev &&
                            (c < 2 || !Test1)) begin
                            m_own[i] = c;
                            m_t[i]   = 0;
                            m_ptr[i] = (c + 1) % 4;
                            if (c == 3) m_ws[i] = wr_src;
                        end
                    end
                end
            end
        end
    end

    // Every cycle: both instances against the model, plus exclusivity.
    always @(posedge CLK) begin
        #1;
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                logic [10:0] e;
                e = exp_vec(i);
                checks++;
                if (ov[i] !== e) begin
                    errors++;
                    $display("FAIL outs[%0d] t=%0t got %b need %b",
                             i, $time, ov[i], e);
                end
                checks++;
                if (ov[i][6] && ov[i][5]) begin
                    errors++;
                    $display("FAIL excl[%0d] t=%0t got both=1 need <=1",
                             i, $time);
                end
            end
        end
    end

    task automatic lit(input string nm, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got %b need %b", nm, $time, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_in();
        Test1   = 1'b0;
        req_res = 1'b0;
        req_dv  = 1'b0;
        req_rd  = 1'b0;
        req_wr  = 1'b0;
        wr_src  = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge CLK);
        #2;
        RESET = 1'b1;
        clear_in();
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RESET = 1'b0;
    endtask

    task automatic drain();
        int n;
        clear_in();
        n = 0;
        while ((a_busy || b_busy) && n < 60) begin
            tick();
            n++;
        end
        checks++;
        if (a_busy || b_busy) begin
            errors++;
            $display("FAIL drain_timeout t=%0t got busy=%b%b need 00",
                     $time, a_busy, b_busy);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        chk_en = 1'b0;
        RESET  = 1'b0;
        clear_in();
        #1;
        do_reset();
        chk_en = 1'b1;

        lit("rst_busy", a_busy, 1'b0);
        lit("rst_gnt", a_gres | a_gdv | a_grd | a_gwr, 1'b0);

        // single res transfer, hold 1
        req_res = 1'b1;
        tick();
        lit("s1_c1_gres", a_gres, 1'b1);
        lit("s1_c1_dlc", a_dlc, 1'b0);
        tick();
        lit("s1_c2_dlc", a_dlc, 1'b1);
        tick();
        lit("s1_c3_done", a_done, 1'b1);
        lit("s1_c3_smp", a_smp, 1'b1);
        lit("s1_c3_gres", a_gres, 1'b1);
        lit("s1_c3_dlc", a_dlc, 1'b0);
        req_res = 1'b0;
        tick();
        lit("s1_c4_busy", a_busy, 1'b0);
        drain();

        // all four held, hold 1: grant order res,dv,rd,wr,res
        do_reset();
        req_res = 1'b1;
        req_dv  = 1'b1;
        req_rd  = 1'b1;
        req_wr  = 1'b1;
        for (int c = 1; c <= 13; c++) begin
            tick();
            if (c % 3 == 1) begin
                logic [3:0] g, e;
                g = {a_gres, a_gdv, a_grd, a_gwr};
                case ((c / 3) % 4)
                    0: e = 4'b1000;
                    1: e = 4'b0100;
                    2: e = 4'b0010;
                    default: e = 4'b0001;
                endcase
                checks++;
                if (g !== e) begin
                    errors++;
                    $display("FAIL s2_order c=%0d got %b need %b", c, g, e);
                end
            end
            if (c == 3) lit("s2_c3_done", a_done, 1'b1);
            if (c == 4) lit("s2_c4_busy", a_busy, 1'b1);
        end
        drain();

        // write from DV, hold 3; request drops mid-transfer
        do_reset();
        req_wr = 1'b1;
        wr_src = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            tick();
            lit("s3_dout", b_dout, (c >= 2 && c <= 4));
            lit("s3_ext", b_ext, (c >= 2 && c <= 4));
            lit("s3_dlc", b_dlc, 1'b0);
            lit("s3_done", b_done, (c == 5));
            lit("s3_smp", b_smp, 1'b0);
            if (c == 3) begin
                req_wr = 1'b0;
                wr_src = 1'b0;
            end
        end
        drain();

        // read aborted by Test1 in first drive cycle
        do_reset();
        req_rd = 1'b1;
        tick();
        lit("s4_c1_grd", b_grd, 1'b1);
        tick();
        Test1 = 1'b1;
        tick();
        lit("s4_c3_abort", b_abort, 1'b1);
        lit("s4_c3_grd", b_grd, 1'b0);
        lit("s4_c3_done", b_done, 1'b0);
        lit("s4_c3_busy", b_busy, 1'b0);
        lit("s4_c3_abort_a", a_abort, 1'b1);
        tick();
        lit("s4_c4_abort", b_abort, 1'b0);
        lit("s4_c4_busy", b_busy, 1'b0);
        Test1 = 1'b0;
        tick();
        lit("s4_c5_grd", b_grd, 1'b1);
        drain();

        // Test1 masks rd while dv proceeds
        do_reset();
        Test1  = 1'b1;
        req_rd = 1'b1;
        req_dv = 1'b1;
        tick();
        lit("s5_c1_gdv", a_gdv, 1'b1);
        lit("s5_c1_grd", a_grd, 1'b0);
        tick();
        tick();
        lit("s5_c3_done", a_done, 1'b1);
        req_dv = 1'b0;
        tick();
        lit("s5_c4_busy", a_busy, 1'b0);
        tick();
        lit("s5_c5_grd", a_grd, 1'b0);
        Test1 = 1'b0;
        tick();
        lit("s5_c6_grd", a_grd, 1'b1);
        drain();

        // reset during drive of a res transfer
        do_reset();
        req_res = 1'b1;
        tick();
        tick();
        lit("s6_c2_dlc", b_dlc, 1'b1);
        req_dv = 1'b1;
        #1;
        RESET = 1'b1;
        #1;
        checks++;
        if (ov[0] !== 11'd0 || ov[1] !== 11'd0) begin
            errors++;
            $display("FAIL s6_async got %b %b need all 0", ov[0], ov[1]);
        end
        @(posedge CLK);
        #1;
        RESET   = 1'b0;
        req_res = 1'b0;
        tick();
        lit("s6_gdv_a", a_gdv, 1'b1);
        lit("s6_gdv_b", b_gdv, 1'b1);
        drain();

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
